avst_frame_tx: RTL and testbench
================================

// Module: avst_frame_tx
// PURPOSE
//  Sensor-side transmitter for the Avalon-ST video stream consumed by the line-buffer filters.
//  Converts a parallel sensor bus (frame-valid / line-valid / data) into fixed-size frames.
//  Every frame carries exactly FRAME_HEIGHT x FRAME_WIDTH valid beats, with sop on the first beat and eop on the last.
//  Downstream filters count pixels and lines, so malformed input frames are repaired or closed and then flagged.
// PARAMETERS
//  DATA_WIDTH    16   pixel width
//  FRAME_WIDTH   640  beats per output line
//  FRAME_HEIGHT  512  lines per output frame
//  PAD_VALUE     0    data value for padded beats
//  LINE_GAP      4    idle cycles between consecutive padded lines (>=1)
// PORTS
//  clk           in   1   clock
//  reset_n       in   1   synchronous active-low reset
//  sen_fval      in   1   sensor frame valid
//  sen_lval      in   1   sensor line valid; one pixel per cycle while high
//  sen_data      in   DW  sensor pixel
//  source_valid  out  1   Avalon-ST valid (no ready; sink always accepts)
//  source_sop    out  1   start of packet
//  source_eop    out  1   end of packet
//  source_data   out  DW  pixel
//  frame_err     out  1   1-cycle pulse, current frame malformed
//  frame_cnt     out  16  frames emitted (counts eop beats), wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): all outputs 0, pix_cnt=line_cnt=0, state SYNC. Reset mid-frame aborts with no eop.
//  - All outputs registered. A sensor pixel at cycle n appears on source_* at n+1.
//  - sop and eop are asserted only together with source_valid. The sop beat is (line0, pix0). The eop beat is (line H-1, pix W-1).
//  - FSM states and transitions:
//      SYNC: wait for sen_fval=0. Out of reset, a frame already in progress is skipped. Then go to IDLE.
//      IDLE: on a rising edge of sen_fval, go to LWAIT with line_cnt=0.
//      LWAIT: a rising sen_lval goes to LINE and forwards that pixel (pix_cnt=1).
//             sen_fval falling with line_cnt<H goes to PAD_F (short frame).
//      LINE: forward each pixel while sen_lval=1.
//             At pix_cnt=W, extra pixels are dropped and frame_err pulses once (long line).
//             When sen_lval falls with pix_cnt<W, go to PAD_L. When sen_lval falls with pix_cnt=W, line_cnt++.
//             Then go to DONE if line_cnt=H, otherwise to LWAIT.
//      PAD_L: emit PAD_VALUE beats back-to-back until pix_cnt=W, then line_cnt++ and go to LWAIT or DONE.
//             A rising sen_lval during PAD_L drops that sensor line, does not count it, and pulses frame_err.
//      PAD_F: emit the remaining lines of PAD_VALUE, with LINE_GAP idle cycles between lines.
//             eop goes on the final pad beat. frame_err pulses on entry. Then go to IDLE.
//      DONE: eop has been emitted. Lines arriving before sen_fval falls are dropped, with one frame_err pulse (long frame).
//             sen_fval=0 goes to IDLE.
//  - When sen_fval falls during LINE: close the line as if sen_lval fell, then follow PAD_L/PAD_F rules.
//  - H=1 and W=1: sop and eop on the same beat.
//  - frame_cnt increments on each eop beat.
//  - Counters are 16-bit. Only compare pix_cnt against W and line_cnt against H.
//  - A simultaneous sen_fval rise and sen_lval rise counts as the frame start plus the first pixel.
// CONFIGURATION
//  AVST_TX_PAD_EN defined: padding enabled exactly as above.
//  AVST_TX_PAD_EN undefined (behaviour in each case):
//   - PAD_L and PAD_F are removed.
//   - Short line: pix_cnt is reset and line_cnt++. No pad beats are emitted. frame_err pulses.
//   - Short frame (sen_fval falls, line_cnt<H): emit one beat with source_valid=1, source_eop=1, data=PAD_VALUE.
//     frame_err pulses and frame_cnt increments.
//   - The beat count per frame is then not guaranteed.
// TESTING (W=8, H=4, LINE_GAP=2, PAD_VALUE=0xAAAA)
//  1 Nominal: 4 lines x 8 px, data=line*16+pix.
//    Expect 32 beats matching, sop on 0x0000, eop on 0x0037, frame_err never, frame_cnt=1.
//  2 Short line: line1 has 5 px.
//    Expect 3 beats of 0xAAAA immediately after, 32 total beats, 1 frame_err pulse, eop still on 0x0037.
//  3 Short frame: sen_fval falls after 2 lines.
//    Expect 16 pad beats with a 2-cycle gap between lines, eop on the last pad, 1 frame_err pulse.
//  4 Long line/frame: line0 has 10 px and a 5th line arrives.
//    Expect px 8-9 and line 4 dropped, 32 beats, 2 frame_err pulses.
//  5 Reset release while sen_fval=1 mid-frame.
//    Expect no output until the next sen_fval rise, then a nominal frame.
//    Assert reset mid-frame: outputs 0 next cycle, no eop.
//  6 Build without AVST_TX_PAD_EN, repeat test 3.
//    Expect 16 data beats, then a single 0xAAAA eop beat, 1 frame_err pulse, frame_cnt=1.

Source files
------------

// File: rtl/avst_frame_tx.sv
// avst_frame_tx: turns a sensor fval/lval/data bus into fixed-size Avalon-ST frames, repairing and flagging malformed input.
// Define AVST_TX_PAD_EN to pad short lines/frames to full size; undefined, short frames are closed by a single PAD_VALUE eop beat.
module avst_frame_tx #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    FRAME_WIDTH  = 640,
    parameter int                    FRAME_HEIGHT = 512,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE    = '0,
    parameter int                    LINE_GAP     = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sen_fval,
    input  logic                  sen_lval,
    input  logic [DATA_WIDTH-1:0] sen_data,
    output logic                  source_valid,
    output logic                  source_sop,
    output logic                  source_eop,
    output logic [DATA_WIDTH-1:0] source_data,
    output logic                  frame_err,
    output logic [15:0]           frame_cnt
);
    localparam logic [15:0] W16 = 16'(FRAME_WIDTH);
    localparam logic [15:0] H16 = 16'(FRAME_HEIGHT);

    if (LINE_GAP < 1) begin : g_gap_check
        $error("avst_frame_tx: LINE_GAP must be at least 1");
    end

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_LWAIT,
        S_LINE,
`ifdef AVST_TX_PAD_EN
        S_PAD_L,
        S_PAD_F,
`endif
        S_DONE
    } state_t;

    state_t                r_state;
    logic [15:0]           r_pix_cnt;
    logic [15:0]           r_line_cnt;
    logic                  r_err_flag;
    logic                  r_fval_d;
    logic                  r_lval_d;
    logic                  r_valid;
    logic                  r_sop;
    logic                  r_eop;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_err;
    logic [15:0]           r_frame_cnt;
`ifdef AVST_TX_PAD_EN
    logic [15:0]           r_gap_cnt;
    logic [15:0]           w_gap_next;
`endif

    state_t                w_state_next;
    logic [15:0]           w_pix_next;
    logic [15:0]           w_line_next;
    logic                  w_err_flag_next;
    logic                  w_valid_next;
    logic                  w_sop_next;
    logic                  w_eop_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_err_next;
    logic                  w_fwd;
    logic                  w_pad;
    logic                  w_pad_line;
    logic                  w_line_done;
    logic                  w_abort;

    // IDLE leaves stale counts behind; treat them as zero so a frame can start on the first IDLE cycle
    logic [15:0] w_pix_cur;
    logic [15:0] w_line_cur;
    logic        w_fval_rise;
    logic        w_lval_rise;
    logic        w_pix_last;
    logic        w_line_last;
    logic        w_lwait_act;

    assign w_pix_cur   = (r_state == S_IDLE) ? 16'd0 : r_pix_cnt;
    assign w_line_cur  = (r_state == S_IDLE) ? 16'd0 : r_line_cnt;
    assign w_fval_rise = sen_fval & ~r_fval_d;
    assign w_lval_rise = sen_lval & ~r_lval_d;
    assign w_pix_last  = ((w_pix_cur + 16'd1) == W16);
    assign w_line_last = ((w_line_cur + 16'd1) == H16);
    assign w_lwait_act = (r_state == S_LWAIT) || ((r_state == S_IDLE) && w_fval_rise);

    always_comb begin
        w_state_next    = r_state;
        w_pix_next      = r_pix_cnt;
        w_line_next     = r_line_cnt;
        w_err_flag_next = r_err_flag;
        w_err_next      = 1'b0;
        w_fwd           = 1'b0;
        w_pad           = 1'b0;
        w_pad_line      = 1'b0;
        w_line_done     = 1'b0;
        w_abort         = 1'b0;
`ifdef AVST_TX_PAD_EN
        w_gap_next      = r_gap_cnt;
`endif
        unique case (r_state)
            S_SYNC: begin
                if (!sen_fval) w_state_next = S_IDLE;
            end
            S_IDLE, S_LWAIT: begin
                if ((r_state == S_IDLE) && w_fval_rise) begin
                    w_state_next    = S_LWAIT;
                    w_line_next     = 16'd0;
                    w_pix_next      = 16'd0;
                    w_err_flag_next = 1'b0;
                end
                if (w_lwait_act) begin
                    if (!sen_fval) begin
                        w_err_next = 1'b1;
`ifdef AVST_TX_PAD_EN
                        w_state_next = S_PAD_F;
                        w_gap_next   = 16'd0;
`else
                        w_abort      = 1'b1;
                        w_state_next = S_IDLE;
`endif
                    end else if (w_lval_rise) begin
                        w_fwd           = 1'b1;
                        w_pix_next      = w_pix_cur + 16'd1;
                        w_err_flag_next = 1'b0;
                        w_state_next    = S_LINE;
                    end
                end
            end
            S_LINE: begin
                if (!sen_fval || !sen_lval) begin
                    if (w_pix_cur == W16) begin
                        w_line_done = 1'b1;
                    end else begin
                        w_err_next = 1'b1;
`ifdef AVST_TX_PAD_EN
                        w_pad_line   = 1'b1;
                        w_state_next = S_PAD_L;
`else
                        w_line_done  = 1'b1;
`endif
                    end
                end else if (w_pix_cur == W16) begin
                    if (!r_err_flag) begin
                        w_err_next      = 1'b1;
                        w_err_flag_next = 1'b1;
                    end
                end else begin
                    w_fwd      = 1'b1;
                    w_pix_next = w_pix_cur + 16'd1;
                end
            end
`ifdef AVST_TX_PAD_EN
            S_PAD_L: begin
                w_pad_line = 1'b1;
                if (w_lval_rise) w_err_next = 1'b1;
            end
            S_PAD_F: begin
                if (r_gap_cnt != 16'd0) begin
                    w_gap_next = r_gap_cnt - 16'd1;
                end else begin
                    w_pad = 1'b1;
                    if (w_pix_last) begin
                        w_pix_next  = 16'd0;
                        w_line_next = w_line_cur + 16'd1;
                        if (w_line_last) w_state_next = S_IDLE;
                        else             w_gap_next   = 16'(LINE_GAP);
                    end else begin
                        w_pix_next = w_pix_cur + 16'd1;
                    end
                end
            end
`endif
            S_DONE: begin
                if (!sen_fval) begin
                    w_state_next = S_IDLE;
                end else if (w_lval_rise && !r_err_flag) begin
                    w_err_next      = 1'b1;
                    w_err_flag_next = 1'b1;
                end
            end
            default: w_state_next = S_SYNC;
        endcase

        if (w_pad_line) begin
            w_pad = 1'b1;
            if (w_pix_last) w_line_done = 1'b1;
            else            w_pix_next  = w_pix_cur + 16'd1;
        end
        if (w_line_done) begin
            w_pix_next      = 16'd0;
            w_line_next     = w_line_cur + 16'd1;
            w_err_flag_next = 1'b0;
            w_state_next    = w_line_last ? S_DONE : S_LWAIT;
        end

        w_valid_next = 1'b0;
        w_sop_next   = 1'b0;
        w_eop_next   = 1'b0;
        w_data_next  = '0;
        if (w_fwd || w_pad || w_abort) begin
            w_valid_next = 1'b1;
            w_data_next  = w_fwd ? sen_data : PAD_VALUE;
            w_sop_next   = (w_line_cur == 16'd0) && (w_pix_cur == 16'd0);
            w_eop_next   = w_abort | (w_line_last & w_pix_last);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_SYNC;
            r_pix_cnt   <= 16'd0;
            r_line_cnt  <= 16'd0;
            r_err_flag  <= 1'b0;
            r_fval_d    <= 1'b0;
            r_lval_d    <= 1'b0;
            r_valid     <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_data      <= '0;
            r_err       <= 1'b0;
            r_frame_cnt <= 16'd0;
`ifdef AVST_TX_PAD_EN
            r_gap_cnt   <= 16'd0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_pix_cnt   <= w_pix_next;
            r_line_cnt  <= w_line_next;
            r_err_flag  <= w_err_flag_next;
            r_fval_d    <= sen_fval;
            r_lval_d    <= sen_lval;
            r_valid     <= w_valid_next;
            r_sop       <= w_sop_next;
            r_eop       <= w_eop_next;
            r_data      <= w_data_next;
            r_err       <= w_err_next;
            r_frame_cnt <= r_frame_cnt + {15'd0, w_eop_next};
`ifdef AVST_TX_PAD_EN
            r_gap_cnt   <= w_gap_next;
`endif
        end
    end

    assign source_valid = r_valid;
    assign source_sop   = r_sop;
    assign source_eop   = r_eop;
    assign source_data  = r_data;
    assign frame_err    = r_err;
    assign frame_cnt    = r_frame_cnt;
endmodule

// File: tb/tb_avst_frame_tx.sv
// Directed bench for avst_frame_tx (W=8, H=4, LINE_GAP=2, PAD_VALUE=0xAAAA); expectations follow AVST_TX_PAD_EN.
module tb_avst_frame_tx;
    localparam logic [15:0] PADV = 16'hAAAA;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sen_fval = 1'b0;
    logic        sen_lval = 1'b0;
    logic [15:0] sen_data = '0;
    logic        source_valid, source_sop, source_eop, frame_err;
    logic [15:0] source_data, frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_pulses = 0;
    int proto_bad = 0;
    logic [15:0] cap_data[$];
    logic        cap_sop[$];
    logic        cap_eop[$];
    int          cap_cyc[$];
    logic [15:0] exp_q[$];
    int          line_len[8];

    avst_frame_tx #(
        .DATA_WIDTH(16), .FRAME_WIDTH(8), .FRAME_HEIGHT(4), .PAD_VALUE(PADV), .LINE_GAP(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sen_fval(sen_fval), .sen_lval(sen_lval), .sen_data(sen_data),
        .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
        .source_data(source_data), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (source_valid) begin
            cap_data.push_back(source_data);
            cap_sop.push_back(source_sop);
            cap_eop.push_back(source_eop);
            cap_cyc.push_back(cyc);
            $display("beat cyc=%0d data=%04h sop=%0b eop=%0b", cyc, source_data, source_sop, source_eop);
        end
        if (frame_err) err_pulses <= err_pulses + 1;
        if (!source_valid && (source_sop || source_eop)) proto_bad <= proto_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cyc_at(input int idx);
        return (idx < cap_cyc.size()) ? cap_cyc[idx] : -1000;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sen_lval = 1'b0;
            sen_data = '0;
        end
    endtask

    task automatic drive_line(input int l, input int n);
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            sen_lval = 1'b1;
            sen_data = 16'(l * 16 + p);
        end
        @(negedge clk);
        sen_lval = 1'b0;
        sen_data = '0;
    endtask

    task automatic send_frame(input int nl);
        @(negedge clk);
        sen_fval = 1'b1;
        idle(2);
        for (int l = 0; l < nl; l++) begin
            drive_line(l, line_len[l]);
            idle(3);
        end
        @(negedge clk);
        sen_fval = 1'b0;
        idle(30);
    endtask

    task automatic exp_line(input int l, input int n);
        for (int p = 0; p < n; p++) exp_q.push_back(16'(l * 16 + p));
    endtask

    task automatic exp_pad(input int n);
        repeat (n) exp_q.push_back(PADV);
    endtask

    task automatic verify(input string tag, input int b, input int e0, input int exp_err,
                          input logic [15:0] exp_fcnt);
        int n;
        int ns;
        int ne;
        n  = cap_data.size() - b;
        ns = 0;
        ne = 0;
        chk({tag, " beats"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            if (i < exp_q.size())
                chk($sformatf("%s data[%0d]", tag, i), 32'(cap_data[b + i]), 32'(exp_q[i]));
            if (cap_sop[b + i]) ns++;
            if (cap_eop[b + i]) ne++;
        end
        chk({tag, " sop count"}, 32'(ns), 32'd1);
        chk({tag, " eop count"}, 32'(ne), 32'd1);
        if (n > 0) begin
            chk({tag, " sop first"}, 32'(cap_sop[b]), 32'd1);
            chk({tag, " eop last"}, 32'(cap_eop[b + n - 1]), 32'd1);
        end
        chk({tag, " frame_err pulses"}, 32'(err_pulses - e0), 32'(exp_err));
        chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(exp_fcnt));
        $display("frame %s: beats=%0d err=%0d frame_cnt=%0d", tag, n, err_pulses - e0, frame_cnt);
    endtask

    initial begin
        int b;
        int e0;
        int ne;

        repeat (3) @(negedge clk);
        chk("rst valid", 32'(source_valid), 32'd0);
        chk("rst sop", 32'(source_sop), 32'd0);
        chk("rst eop", 32'(source_eop), 32'd0);
        chk("rst data", 32'(source_data), 32'd0);
        chk("rst err", 32'(frame_err), 32'd0);
        chk("rst frame_cnt", 32'(frame_cnt), 32'd0);
        reset_n = 1'b1;
        idle(3);

        // nominal frame
        line_len = '{8, 8, 8, 8, 0, 0, 0, 0};
        b = cap_data.size(); e0 = err_pulses;
        send_frame(4);
        exp_q.delete();
        for (int l = 0; l < 4; l++) exp_line(l, 8);
        verify("nominal", b, e0, 0, 16'd1);

        // short line 1
        line_len = '{8, 5, 8, 8, 0, 0, 0, 0};
        b = cap_data.size(); e0 = err_pulses;
        send_frame(4);
        exp_q.delete();
        exp_line(0, 8);
        exp_line(1, 5);
`ifdef AVST_TX_PAD_EN
        exp_pad(3);
`endif
        exp_line(2, 8);
        exp_line(3, 8);
        verify("short_line", b, e0, 1, 16'd2);
`ifdef AVST_TX_PAD_EN
        chk("short_line pad adjacent", 32'(cyc_at(b + 13) - cyc_at(b + 12)), 32'd1);
`endif

        // short frame: fval falls after two lines
        line_len = '{8, 8, 0, 0, 0, 0, 0, 0};
        b = cap_data.size(); e0 = err_pulses;
        send_frame(2);
        exp_q.delete();
        exp_line(0, 8);
        exp_line(1, 8);
`ifdef AVST_TX_PAD_EN
        exp_pad(16);
`else
        exp_pad(1);
`endif
        verify("short_frame", b, e0, 1, 16'd3);
`ifdef AVST_TX_PAD_EN
        chk("short_frame line gap", 32'(cyc_at(b + 24) - cyc_at(b + 23)), 32'd3);
        chk("short_frame pad line span", 32'(cyc_at(b + 23) - cyc_at(b + 16)), 32'd7);
`endif

        // long line 0 plus a fifth line
        line_len = '{10, 8, 8, 8, 8, 0, 0, 0};
        b = cap_data.size(); e0 = err_pulses;
        send_frame(5);
        exp_q.delete();
        for (int l = 0; l < 4; l++) exp_line(l, 8);
        verify("long", b, e0, 2, 16'd4);

        // reset asserted mid-frame, released while fval is still high
        b = cap_data.size();
        @(negedge clk);
        sen_fval = 1'b1;
        idle(2);
        drive_line(0, 8);
        idle(3);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            sen_lval = 1'b1;
            sen_data = 16'(16 + p);
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst valid", 32'(source_valid), 32'd0);
        chk("midrst sop", 32'(source_sop), 32'd0);
        chk("midrst eop", 32'(source_eop), 32'd0);
        chk("midrst data", 32'(source_data), 32'd0);
        chk("midrst frame_cnt", 32'(frame_cnt), 32'd0);
        chk("midrst beats before reset", 32'(cap_data.size() - b), 32'd11);
        ne = 0;
        for (int i = b; i < cap_eop.size(); i++) if (cap_eop[i]) ne++;
        chk("midrst no eop", 32'(ne), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        b = cap_data.size(); e0 = err_pulses;
        for (int p = 3; p < 8; p++) begin
            @(negedge clk);
            sen_lval = 1'b1;
            sen_data = 16'(16 + p);
        end
        idle(4);
        drive_line(2, 8);
        idle(3);
        drive_line(3, 8);
        idle(3);
        @(negedge clk);
        sen_fval = 1'b0;
        idle(5);
        chk("sync beats", 32'(cap_data.size() - b), 32'd0);
        chk("sync err", 32'(err_pulses - e0), 32'd0);
        chk("sync frame_cnt", 32'(frame_cnt), 32'd0);

        line_len = '{8, 8, 8, 8, 0, 0, 0, 0};
        b = cap_data.size(); e0 = err_pulses;
        send_frame(4);
        exp_q.delete();
        for (int l = 0; l < 4; l++) exp_line(l, 8);
        verify("post_reset", b, e0, 0, 16'd1);

        chk("sop/eop without valid", 32'(proto_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
